// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, PC step and queue entry type for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int IMEM_AW = 7;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry circular buffer of fetch entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_wdata;
        r_tail        <= r_tail + 1'b1;
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : LEGv8 fetch stage: fetch PC, ROM addressing, output queue, redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N     = PC_W,
  parameter int IW    = INSTR_W,
  parameter int DEPTH = 2,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [IW-1:0]      imem_q,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW-1:0]      out_instr,
  output logic [N-1:0]       out_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [N-1:0]  r_fetch_pc;
  logic [CW-1:0] w_count;
  logic          w_pop;
  logic          w_push;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;
  logic          w_unused;

  assign imem_addr = r_fetch_pc[IMEM_AW+1:2];

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;
  // A full queue can still accept a new entry when the head leaves this cycle.
  assign w_push    = !redirect_valid && ((w_count != c_FULL) || w_pop);

  assign w_wdata.pc    = r_fetch_pc;
  assign w_wdata.instr = imem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[N-1:2], 2'b00};
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + N'(PC_STEP);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  assign w_unused = ^redirect_pc[1:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed vector bench for fetch_stage against a small ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  logic [31:0] rom [128];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  typedef struct {
    bit          rst;
    bit          ready;
    bit          redir;
    logic [63:0] rpc;
    bit          exp_valid;
    logic [6:0]  exp_addr;
    bit          chk_data;
    logic [31:0] exp_instr;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit rst, bit ready, bit redir, logic [63:0] rpc,
                              bit v, logic [6:0] a, bit chk,
                              logic [31:0] ins, logic [63:0] pc);
    vec_t t;
    t.rst = rst; t.ready = ready; t.redir = redir; t.rpc = rpc;
    t.exp_valid = v; t.exp_addr = a; t.chk_data = chk;
    t.exp_instr = ins; t.exp_pc = pc;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, bit v, logic [6:0] a, bit chk,
                               logic [31:0] ins, logic [63:0] pc);
    check({tag, " valid"}, 64'(out_valid), 64'(v));
    check({tag, " addr"}, 64'(imem_addr), 64'(a));
    if (chk) begin
      check({tag, " instr"}, 64'(out_instr), 64'(ins));
      check({tag, " pc"}, out_pc, pc);
    end
  endtask

  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h0;
    rom[0] = 32'hf8000001;
    rom[1] = 32'hf8008002;
    rom[2] = 32'hf8000203;
    rom[3] = 32'h8b050083;

    //            rst rdy red rpc      v  addr chk instr         pc
    // streaming after reset
    vq.push_back(mk(1, 1, 0, 64'h0,   0, 7'd0, 1, 32'h0,        64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd1, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd2, 1, 32'hf8008002, 64'h4));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd3, 1, 32'hf8000203, 64'h8));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd4, 1, 32'h8b050083, 64'hC));
    // back-pressure: queue fills, output frozen, then drains with no gap
    vq.push_back(mk(1, 0, 0, 64'h0,   0, 7'd0, 0, 32'h0,        64'h0));
    vq.push_back(mk(0, 0, 0, 64'h0,   1, 7'd1, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 0, 0, 64'h0,   1, 7'd2, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 0, 0, 64'h0,   1, 7'd2, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 0, 0, 64'h0,   1, 7'd2, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd2, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd3, 1, 32'hf8008002, 64'h4));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd4, 1, 32'hf8000203, 64'h8));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd5, 1, 32'h8b050083, 64'hC));
    // redirect to 0x0C while head pc 4 is accepted
    vq.push_back(mk(1, 1, 0, 64'h0,   0, 7'd0, 0, 32'h0,        64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd1, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 1, 1, 64'hC,   1, 7'd2, 1, 32'hf8008002, 64'h4));
    vq.push_back(mk(0, 1, 0, 64'h0,   0, 7'd3, 0, 32'h0,        64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd4, 1, 32'h8b050083, 64'hC));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd5, 1, 32'h0,        64'h10));
    // misaligned redirect target 0x0E aligns to 0x0C
    vq.push_back(mk(1, 1, 0, 64'h0,   0, 7'd0, 0, 32'h0,        64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd1, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 1, 1, 64'hE,   1, 7'd2, 1, 32'hf8008002, 64'h4));
    vq.push_back(mk(0, 1, 0, 64'h0,   0, 7'd3, 0, 32'h0,        64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd4, 1, 32'h8b050083, 64'hC));
    // redirect to 0x1FC: ROM address aliases at 0x200
    vq.push_back(mk(1, 1, 1, 64'h1FC, 0, 7'd0, 0, 32'h0,        64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   0, 7'd127, 0, 32'h0,      64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd0, 1, 32'h0,        64'h1FC));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd1, 1, 32'hf8000001, 64'h200));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd2, 1, 32'hf8008002, 64'h204));
    // PC wraps modulo 2^64; redirect with a stalled, full queue discards it
    vq.push_back(mk(1, 0, 0, 64'h0,   0, 7'd0, 0, 32'h0,        64'h0));
    vq.push_back(mk(0, 0, 0, 64'h0,   1, 7'd1, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 0, 1, TOP_PC,  1, 7'd2, 1, 32'hf8000001, 64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   0, 7'd127, 0, 32'h0,      64'h0));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd0, 1, 32'h0,        TOP_PC));
    vq.push_back(mk(0, 1, 0, 64'h0,   1, 7'd1, 1, 32'hf8000001, 64'h0));

    repeat (2) @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      if (vq[i].rst) begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
      end
      out_ready      = vq[i].ready;
      redirect_valid = vq[i].redir;
      redirect_pc    = vq[i].rpc;
      #1;
      check_outputs($sformatf("v%0d", i), vq[i].exp_valid, vq[i].exp_addr,
                    vq[i].chk_data, vq[i].exp_instr, vq[i].exp_pc);
    end

    // asynchronous reset with a full queue, asserted between edges
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs("full_before_rst", 1, 7'd2, 1, 32'hf8000001, 64'h0);
    reset = 1'b0;
    #1;
    check_outputs("async_rst", 0, 7'd0, 1, 32'h0, 64'h0);
    @(posedge clk);
    #1;
    check_outputs("rst_held_edge", 0, 7'd0, 1, 32'h0, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    check_outputs("rst_release", 0, 7'd0, 0, 32'h0, 64'h0);
    @(negedge clk);
    #1;
    check_outputs("restart0", 1, 7'd1, 1, 32'hf8000001, 64'h0);
    @(negedge clk);
    #1;
    check_outputs("restart1", 1, 7'd2, 1, 32'hf8008002, 64'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
